// File: rtl/avalon_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer, plus its interrupt line.
interface avalon_multi_timer_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [15:0]       writedata;
    logic [15:0]       readdata;
    logic              irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/avalon_multi_timer.sv
// NUM_CH independent prescaled down-counters behind a 16-bit Avalon-MM slave.
// Each channel has its own timeout flag; the enabled flags are ORed onto one irq.
module avalon_multi_timer #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int PRESCALE_W   = 8,
    parameter int RESET_PERIOD = 49999
) (
    input  logic                 clk,
    input  logic                 reset_n,
    avalon_multi_timer_if.slave  bus
);
    localparam int              ADDR_W  = 3 + $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);

    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_ch;
    logic [2:0]        w_reg;
    logic              w_ch_ok;
    logic              w_wr;
    logic [NUM_CH-1:0] w_pend;
    logic [15:0]       w_ch_rd [NUM_CH];
    logic [15:0]       w_rd_data;
    logic [15:0]       r_readdata;

    // Shift rather than slice so a single-channel build (no channel field) still works.
    assign w_addr  = bus.address;
    assign w_ch    = w_addr >> 3;
    assign w_reg   = w_addr[2:0];
    assign w_ch_ok = (w_ch < ADDR_W'(NUM_CH));
    assign w_wr    = bus.chipselect & ~bus.write_n & w_ch_ok;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0]      r_period;
            logic [CNT_W-1:0]      r_counter;
            logic [CNT_W-1:0]      r_snap;
            logic [PRESCALE_W-1:0] r_presc;
            logic [PRESCALE_W-1:0] r_presc_cnt;
            logic [3:0]            r_ctrl;
            logic                  r_run;
            logic                  r_to;
            logic                  r_zero_d;
            logic                  r_force_reload;
            logic                  w_sel;
            logic                  w_zero;
            logic                  w_tick;
            logic                  w_event;
            logic                  w_start;
            logic                  w_stop;
            logic                  w_to_clr;
            logic [31:0]           w_period32;
            logic [31:0]           w_snap32;
            logic [15:0]           w_rd;

            assign w_sel    = w_wr && (w_ch == ADDR_W'(gi));
            assign w_zero   = (r_counter == '0);
            assign w_tick   = r_run && (r_presc_cnt == r_presc);
            assign w_event  = w_zero && !r_zero_d;
            assign w_start  = w_sel && (w_reg == 3'd1) && bus.writedata[2];
            assign w_stop   = w_sel && (w_reg == 3'd1) && bus.writedata[3];
            assign w_to_clr = (w_sel && (w_reg == 3'd0)) ||
                              (w_wr && (w_reg == 3'd7) && bus.writedata[gi]);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_period       <= RST_VAL;
                    r_counter      <= RST_VAL;
                    r_snap         <= '0;
                    r_presc        <= '0;
                    r_presc_cnt    <= '0;
                    r_ctrl         <= '0;
                    r_run          <= 1'b0;
                    r_to           <= 1'b0;
                    r_zero_d       <= 1'b0;
                    r_force_reload <= 1'b0;
                end else begin
                    r_force_reload <= w_sel && ((w_reg == 3'd2) || (w_reg == 3'd3));
                    r_zero_d       <= w_zero;

                    if (w_sel && (w_reg == 3'd2))
                        r_period[15:0] <= bus.writedata;
                    if (w_sel && (w_reg == 3'd3))
                        r_period[CNT_W-1:16] <= bus.writedata[CNT_W-17:0];
                    if (w_sel && (w_reg == 3'd1))
                        r_ctrl <= bus.writedata[3:0];
                    if (w_sel && (w_reg == 3'd6))
                        r_presc <= bus.writedata[PRESCALE_W-1:0];
                    if (w_sel && ((w_reg == 3'd4) || (w_reg == 3'd5)))
                        r_snap <= r_counter;

                    if (r_force_reload) begin
                        r_counter   <= r_period;
                        r_presc_cnt <= '0;
                    end else begin
                        if (!r_run || w_tick)
                            r_presc_cnt <= '0;
                        else
                            r_presc_cnt <= r_presc_cnt + PRESCALE_W'(1);
                        // A one-shot channel parks at zero instead of reloading.
                        if (w_tick) begin
                            if (!w_zero)
                                r_counter <= r_counter - CNT_W'(1);
                            else if (r_ctrl[1])
                                r_counter <= r_period;
                        end
                    end

                    if (w_start)
                        r_run <= 1'b1;
                    else if (w_stop || r_force_reload || (w_zero && w_tick && !r_ctrl[1]))
                        r_run <= 1'b0;

                    if (w_to_clr)
                        r_to <= 1'b0;
                    else if (w_event)
                        r_to <= 1'b1;
                end
            end

            assign w_period32 = 32'(r_period);
            assign w_snap32   = 32'(r_snap);

            always_comb begin
                w_rd = '0;
                case (w_reg)
                    3'd0:    w_rd = {14'b0, r_run, r_to};
                    3'd1:    w_rd = {12'b0, r_ctrl};
                    3'd2:    w_rd = w_period32[15:0];
                    3'd3:    w_rd = w_period32[31:16];
                    3'd4:    w_rd = w_snap32[15:0];
                    3'd5:    w_rd = w_snap32[31:16];
                    3'd6:    w_rd = 16'(r_presc);
                    default: w_rd = '0;
                endcase
            end

            assign w_ch_rd[gi] = w_rd;
            assign w_pend[gi]  = r_to & r_ctrl[0];
        end
    endgenerate

    always_comb begin
        w_rd_data = '0;
        if (w_ch_ok) begin
            if (w_reg == 3'd7) begin
                w_rd_data = 16'(w_pend);
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (w_ch == ADDR_W'(i))
                        w_rd_data = w_ch_rd[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_readdata <= '0;
        else
            r_readdata <= w_rd_data;
    end

    assign bus.readdata = r_readdata;
    assign bus.irq      = |w_pend;
endmodule
